// File: rtl/pe_dw_cluster_acc.sv
// ============================================================================
// Module  : pe_dw_cluster_acc
// Brief   : Depthwise PE cluster with one signed MAC lane per channel. Each lane
//           accumulates KERNEL_TAPS beats, then requantises to a valid/ready output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_dw_cluster_acc #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 24,
    parameter int KERNEL_TAPS = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_ifm,
    input  logic [NUM_CH*DATA_W-1:0] i_weight,
    input  logic [4:0]               i_out_shift,
    input  logic                     i_relu_en,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [NUM_CH*DATA_W-1:0] o_ofm
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;

    localparam int             TW         = $clog2(KERNEL_TAPS + 1);
    localparam logic [TW-1:0]  C_LAST_TAP = TW'(KERNEL_TAPS - 1);
    // Wide enough that a 31-bit rounding offset never wraps the sum.
    localparam int             RW         = ACC_W + 33;
    localparam logic signed [DATA_W-1:0] C_QMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] C_QMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]    r_state;
    logic [TW-1:0] r_tap_cnt;
    logic          r_alive;
    logic [4:0]    r_shift;
    logic          r_relu;

    logic          w_accept;
    logic          w_first;
    logic          w_last;
    logic          w_done;
    logic [4:0]    w_shift;
    logic          w_relu;

    // in_ready stays low until the first edge after reset is released.
    assign o_in_ready  = r_alive && (r_state != S_OUTPUT);
    assign o_out_valid = (r_state == S_OUTPUT);
    assign w_accept    = i_in_valid && o_in_ready && !i_clear;
    assign w_first     = (r_state == S_IDLE);
    assign w_last      = (r_tap_cnt == C_LAST_TAP);
    assign w_done      = (r_state == S_OUTPUT) && i_out_ready;
    assign w_shift     = w_first ? i_out_shift : r_shift;
    assign w_relu      = w_first ? i_relu_en   : r_relu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tap_cnt <= '0;
            r_alive   <= 1'b0;
            r_shift   <= '0;
            r_relu    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (i_clear) begin
                r_state   <= S_IDLE;
                r_tap_cnt <= '0;
            end else if (w_accept) begin
                r_tap_cnt <= r_tap_cnt + TW'(1);
                if (w_first) begin
                    r_shift <= i_out_shift;
                    r_relu  <= i_relu_en;
                end
                r_state <= w_last ? S_OUTPUT : S_ACCUM;
            end else if (w_done) begin
                r_state   <= S_IDLE;
                r_tap_cnt <= '0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic signed [DATA_W-1:0]   w_a;
        logic signed [DATA_W-1:0]   w_b;
        logic signed [2*DATA_W-1:0] w_prod;
        logic signed [ACC_W-1:0]    w_sum;
        logic signed [RW-1:0]       w_ext;
        logic signed [RW-1:0]       w_rnd;
        logic signed [RW-1:0]       w_sh;
        logic [DATA_W-1:0]          w_q;
        logic signed [ACC_W-1:0]    r_acc;
        logic [DATA_W-1:0]          r_ofm;

        assign w_a    = i_ifm[c*DATA_W +: DATA_W];
        assign w_b    = i_weight[c*DATA_W +: DATA_W];
        assign w_prod = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);
        assign w_sum  = (w_first ? ACC_W'(0) : r_acc) + ACC_W'(w_prod);
        assign w_ext  = RW'(w_sum);
        assign w_rnd  = (w_shift != 5'd0) ? w_ext + (RW'(1) <<< (w_shift - 5'd1)) : w_ext;
        assign w_sh   = w_rnd >>> w_shift;

        always_comb begin
            w_q = w_sh[DATA_W-1:0];
            if (w_sh > RW'(C_QMAX)) begin
                w_q = C_QMAX;
            end else if (w_relu && w_sh[RW-1]) begin
                w_q = '0;
            end else if (w_sh < RW'(C_QMIN)) begin
                w_q = C_QMIN;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_acc <= '0;
                r_ofm <= '0;
            end else if (i_clear) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_ofm <= w_q;
                end
            end else if (w_done) begin
                r_acc <= '0;
            end
        end

        assign o_ofm[c*DATA_W +: DATA_W] = r_ofm;
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_dw_cluster_acc.sv
// ============================================================================
// Module  : tb_pe_dw_cluster_acc
// Brief   : Self-checking bench: vector table, corner-case sequences and a
//           randomized run against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pe_dw_cluster_acc;

    localparam int NC   = 4;
    localparam int DW   = 8;
    localparam int TAPS = 9;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_clear;
    logic           i_in_valid;
    logic           o_in_ready;
    logic [NC*DW-1:0] i_ifm;
    logic [NC*DW-1:0] i_weight;
    logic [4:0]     i_out_shift;
    logic           i_relu_en;
    logic           o_out_valid;
    logic           i_out_ready;
    logic [NC*DW-1:0] o_ofm;

    int checks   = 0;
    int failures = 0;

    pe_dw_cluster_acc #(
        .NUM_CH(NC), .DATA_W(DW), .ACC_W(24), .KERNEL_TAPS(TAPS)
    ) dut (
        .clk(clk), .reset(reset), .i_clear(i_clear),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_ifm(i_ifm), .i_weight(i_weight),
        .i_out_shift(i_out_shift), .i_relu_en(i_relu_en),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_ofm(o_ofm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
        logic [4:0]  sh;
        logic        rl;
        logic [31:0] exp_ofm;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Entry and exit at a falling edge; returns once the beat has been taken.
    task automatic push(input logic [31:0] a, input logic [31:0] w,
                        input logic [4:0] sh, input logic rl);
        int g = 0;
        i_ifm = a; i_weight = w; i_out_shift = sh; i_relu_en = rl;
        i_in_valid = 1'b1;
        while (!o_in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) timeout("push");
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] q);
        int g = 0;
        while (!o_out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) timeout("wait_out");
        q = o_ofm;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
    endtask

    function automatic logic [7:0] requant(input longint sum, input int s, input bit rl);
        longint v;
        longint lo;
        v = sum;
        if (s > 0) v = v + (longint'(1) <<< (s - 1));
        v  = v >>> s;
        lo = rl ? 0 : -128;
        if (v > 127) v = 127;
        if (v < lo)  v = lo;
        return v[7:0];
    endfunction

    vec_t        tbl[6];
    logic [31:0] q;

    initial begin
        tbl[0] = '{32'h01010101, 32'h01010101, 5'd0, 1'b0, 32'h09090909};
        tbl[1] = '{32'h7f7f7f7f, 32'h7f7f7f7f, 5'd0, 1'b0, 32'h7f7f7f7f};
        tbl[2] = '{32'h80808080, 32'h7f7f7f7f, 5'd0, 1'b0, 32'h80808080};
        tbl[3] = '{32'h000000f6, 32'h0000000a, 5'd4, 1'b0, 32'h000000c8};
        tbl[4] = '{32'h000000f6, 32'h0000000a, 5'd4, 1'b1, 32'h00000000};
        tbl[5] = '{32'h02020202, 32'h03030303, 5'd0, 1'b0, 32'h36363636};

        reset = 1'b1; i_clear = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
        i_ifm = '0; i_weight = '0; i_out_shift = '0; i_relu_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_ofm", o_ofm, 0);
        reset = 1'b0;
        chk("post_rst_in_ready_low", o_in_ready, 0);
        @(negedge clk);
        chk("post_rst_in_ready_high", o_in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < TAPS - 1; k++) push(tbl[i].a, tbl[i].w, tbl[i].sh, tbl[i].rl);
            chk($sformatf("vec%0d_pre_valid", i), o_out_valid, 0);
            push(tbl[i].a, tbl[i].w, tbl[i].sh, tbl[i].rl);
            chk($sformatf("vec%0d_latency", i), o_out_valid, 1);
            wait_out(q);
            chk($sformatf("vec%0d_ofm", i), q, tbl[i].exp_ofm);
        end

        // Gapped input, then backpressure hold.
        for (int k = 0; k < TAPS; k++) begin
            push(32'h02020202, 32'h03030303, 5'd0, 1'b0);
            if (k != TAPS - 1) @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", o_out_valid, 1);
            chk("hold_in_ready", o_in_ready, 0);
            chk("hold_ofm", o_ofm, 32'h36363636);
            @(negedge clk);
        end
        // Beat offered during the output handshake is taken one cycle later in IDLE.
        i_ifm = 32'h01010101; i_weight = 32'h01010101; i_out_shift = 5'd0; i_relu_en = 1'b0;
        i_in_valid = 1'b1; i_out_ready = 1'b1;
        chk("handshake_in_ready", o_in_ready, 0);
        @(negedge clk);
        i_out_ready = 1'b0;
        chk("handshake_drop_valid", o_out_valid, 0);
        chk("idle_in_ready", o_in_ready, 1);
        @(negedge clk);
        i_in_valid = 1'b0;
        for (int k = 0; k < TAPS - 1; k++) push(32'h01010101, 32'h01010101, 5'd0, 1'b0);
        wait_out(q);
        chk("overlap_beat_ofm", q, 32'h09090909);

        // Clear mid-accumulation, with a beat offered alongside it.
        for (int k = 0; k < 4; k++) push(32'h02020202, 32'h03030303, 5'd0, 1'b0);
        i_clear = 1'b1; i_in_valid = 1'b1;
        @(negedge clk);
        i_clear = 1'b0; i_in_valid = 1'b0;
        for (int k = 0; k < TAPS - 1; k++) begin
            push(32'h02020202, 32'h03030303, 5'd0, 1'b0);
            chk("clear_no_early_valid", o_out_valid, 0);
        end
        push(32'h02020202, 32'h03030303, 5'd0, 1'b0);
        chk("clear_valid", o_out_valid, 1);
        wait_out(q);
        chk("clear_ofm", q, 32'h36363636);

        // Clear while a result is pending drops it.
        for (int k = 0; k < TAPS; k++) push(32'h01010101, 32'h01010101, 5'd0, 1'b0);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        chk("clear_output_drop", o_out_valid, 0);

        // Asynchronous reset mid-accumulation.
        for (int k = 0; k < 4; k++) push(32'h02020202, 32'h03030303, 5'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_ofm", o_ofm, 0);
        chk("midrst_in_ready", o_in_ready, 0);
        chk("midrst_valid", o_out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < TAPS; k++) push(32'h01010101, 32'h01010101, 5'd0, 1'b0);
        wait_out(q);
        chk("midrst_fresh_ofm", q, 32'h09090909);

        // Randomized results against the reference model.
        for (int n = 0; n < 30; n++) begin
            longint      sum[NC];
            int          sh0;
            bit          rl0;
            logic [31:0] a, w, expv;
            for (int c = 0; c < NC; c++) sum[c] = 0;
            sh0 = 0; rl0 = 0;
            for (int k = 0; k < TAPS; k++) begin
                logic [4:0] sh;
                logic       rl;
                a  = $urandom;
                w  = $urandom;
                sh = 5'($urandom_range(0, 20));
                rl = 1'($urandom_range(0, 1));
                if (k == 0) begin
                    sh0 = int'(sh);
                    rl0 = rl;
                end
                for (int c = 0; c < NC; c++) begin
                    byte ba, bw;
                    ba = a[c*8 +: 8];
                    bw = w[c*8 +: 8];
                    sum[c] += longint'(ba) * longint'(bw);
                end
                push(a, w, sh, rl);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            for (int c = 0; c < NC; c++) expv[c*8 +: 8] = requant(sum[c], sh0, rl0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_out(q);
            chk($sformatf("rand%0d_ofm", n), q, expv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
